// File: rtl/rns_addsub_pipe.sv
// rns_addsub_pipe: two-stage modular add/subtract channel for one RNS residue.
// S1 registers the raw (WIDTH+1)-bit sum/difference; S2 applies the single
// modular correction and presents the result. A global enable stalls both
// stages together under downstream back-pressure.
// Optional feature macro: RNS_ADDSUB_RANGECHK_EN adds an operand range check
// that flags residues >= MODULUS (err = 1, result = 0, not counted).
module rns_addsub_pipe #(
  parameter int WIDTH   = 8,
  parameter int MODULUS = 251,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sub,
  input  logic [WIDTH-1:0] dataa,
  input  logic [WIDTH-1:0] datab,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             err,
  output logic [CNT_W-1:0] red_cnt,
  input  logic             cnt_clr
);

  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] MOD_W   = WIDTH'(MODULUS);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             en_s;
  logic             deliver_s;
  logic [WIDTH:0]   raw_s;
  logic [WIDTH-1:0] fix_s;
  logic             corr_s;

  logic             s1_valid_r;
  logic             s1_sub_r;
  logic [WIDTH:0]   s1_raw_r;
  logic             s2_valid_r;
  logic [WIDTH-1:0] s2_result_r;
  logic             s2_corr_r;
  logic [CNT_W-1:0] red_cnt_r;

  // Whole pipe advances whenever the output slot is empty or being drained.
  assign en_s      = out_ready | ~s2_valid_r;
  assign deliver_s = s2_valid_r & out_ready;
  assign in_ready  = en_s;
  assign out_valid = s2_valid_r;
  assign result    = s2_result_r;
  assign red_cnt   = red_cnt_r;

  // Raw sum or two's-complement difference; the extra MSB is carry or borrow.
  always_comb begin
    raw_s = '0;
    if (sub) begin
      raw_s = {1'b0, dataa} - {1'b0, datab};
    end else begin
      raw_s = {1'b0, dataa} + {1'b0, datab};
    end
  end

  // Single modular correction of the S1 value; true results fit in WIDTH bits.
  always_comb begin
    fix_s  = s1_raw_r[WIDTH-1:0];
    corr_s = 1'b0;
    if (s1_sub_r) begin
      if (s1_raw_r[WIDTH]) begin
        fix_s  = s1_raw_r[WIDTH-1:0] + MOD_W;
        corr_s = 1'b1;
      end else begin
        fix_s  = s1_raw_r[WIDTH-1:0];
        corr_s = 1'b0;
      end
    end else begin
      if (s1_raw_r >= MOD_EXT) begin
        fix_s  = s1_raw_r[WIDTH-1:0] - MOD_W;
        corr_s = 1'b1;
      end else begin
        fix_s  = s1_raw_r[WIDTH-1:0];
        corr_s = 1'b0;
      end
    end
  end

  // Stage 1: capture raw arithmetic, operation and valid (bubble when idle).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_sub_r   <= 1'b0;
      s1_raw_r   <= '0;
    end else if (en_s) begin
      s1_valid_r <= in_valid;
      s1_sub_r   <= sub;
      s1_raw_r   <= raw_s;
    end
  end

`ifdef RNS_ADDSUB_RANGECHK_EN
  logic range_err_s;
  logic s1_err_r;
  logic s2_err_r;

  // Operands outside the residue range are flagged at the input.
  always_comb begin
    range_err_s = 1'b0;
    if (({1'b0, dataa} >= MOD_EXT) || ({1'b0, datab} >= MOD_EXT)) begin
      range_err_s = 1'b1;
    end else begin
      range_err_s = 1'b0;
    end
  end

  // Range flag travels with its operands through stage 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_err_r <= 1'b0;
    end else if (en_s) begin
      s1_err_r <= range_err_s;
    end
  end

  // Stage 2: flagged results are forced to zero and never counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_r  <= 1'b0;
      s2_result_r <= '0;
      s2_corr_r   <= 1'b0;
      s2_err_r    <= 1'b0;
    end else if (en_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_err_r) begin
        s2_result_r <= '0;
        s2_corr_r   <= 1'b0;
        s2_err_r    <= 1'b1;
      end else begin
        s2_result_r <= fix_s;
        s2_corr_r   <= corr_s;
        s2_err_r    <= 1'b0;
      end
    end
  end

  assign err = s2_err_r;
`else
  // Stage 2: corrected result and whether a correction was needed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_r  <= 1'b0;
      s2_result_r <= '0;
      s2_corr_r   <= 1'b0;
    end else if (en_s) begin
      s2_valid_r  <= s1_valid_r;
      s2_result_r <= fix_s;
      s2_corr_r   <= corr_s;
    end
  end

  assign err = 1'b0;
`endif

  // Saturating count of delivered corrected results; clear has priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      red_cnt_r <= '0;
    end else if (cnt_clr) begin
      red_cnt_r <= '0;
    end else if (deliver_s && s2_corr_r && (red_cnt_r != CNT_MAX)) begin
      red_cnt_r <= red_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_rns_addsub_pipe.sv
// Scoreboard bench for rns_addsub_pipe (WIDTH=8, MODULUS=251). The counter
// is built 5 bits wide so saturation is reached in a few dozen results; the
// saturate/clear behaviour does not depend on the width.
module tb_rns_addsub_pipe;

  localparam int TB_CNT_W = 5;
  localparam logic [31:0] CNT_SAT = 32'd31;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                in_valid;
  logic                in_ready;
  logic                sub;
  logic [7:0]          dataa;
  logic [7:0]          datab;
  logic                out_valid;
  logic                out_ready;
  logic [7:0]          result;
  logic                err;
  logic [TB_CNT_W-1:0] red_cnt;
  logic                cnt_clr;

  typedef struct {
    logic [7:0] res;
    logic       er;
    logic       corr;
  } exp_t;

  exp_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] model_cnt = 32'd0;

  rns_addsub_pipe #(.WIDTH(8), .MODULUS(251), .CNT_W(TB_CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .sub(sub), .dataa(dataa), .datab(datab), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .err(err), .red_cnt(red_cnt),
    .cnt_clr(cnt_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: pop and compare on every delivered result, track the counter.
  always @(negedge clk) begin
    exp_t e;
    logic corr;
    corr = 1'b0;
    if (!rst_n) begin
      model_cnt = 32'd0;
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("result", 32'(result), 32'(e.res));
          chk("err", 32'(err), 32'(e.er));
          corr = e.corr;
        end
      end
      chk("red_cnt_model", 32'(red_cnt), model_cnt);
      if (cnt_clr) begin
        model_cnt = 32'd0;
      end else if (out_valid && out_ready && corr && model_cnt != CNT_SAT) begin
        model_cnt = model_cnt + 32'd1;
      end
    end
  end

  // Offer one operand pair; the expectation is queued at the accepting edge.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic s,
                      input logic [7:0] er, input logic ee, input logic ec);
    bit accepted;
    exp_t e;
    accepted = 1'b0;
    in_valid = 1'b1;
    dataa = a;
    datab = b;
    sub = s;
    for (int i = 0; i < 50 && !accepted; i++) begin
      @(negedge clk);
      if (in_ready) begin
        e.res = er; e.er = ee; e.corr = ec;
        exp_q.push_back(e);
        accepted = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!accepted) chk("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) done = 1'b1;
    end
    if (!done) chk("drain_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; sub = 1'b0; dataa = 8'd0; datab = 8'd0;
    out_ready = 1'b0; cnt_clr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_red_cnt", 32'(red_cnt), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_after_rst", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 out_ready = 1'b1;

    // 200+100 = 300 -> 49, corrected; exactly two cycles of latency.
    send(8'd200, 8'd100, 1'b0, 8'd49, 1'b0, 1'b1);
    @(negedge clk);
    chk("lat_not_yet", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("lat_valid", 32'(out_valid), 32'd1);
    drain();
    chk("cnt_after_first", 32'(red_cnt), 32'd1);

    // Subtract with and without borrow, add just below the modulus.
    send(8'd10, 8'd20, 1'b1, 8'd241, 1'b0, 1'b1);
    send(8'd20, 8'd10, 1'b1, 8'd10, 1'b0, 1'b0);
    send(8'd250, 8'd0, 1'b0, 8'd250, 1'b0, 1'b0);
    drain();
    chk("cnt_after_sub", 32'(red_cnt), 32'd2);

`ifdef RNS_ADDSUB_RANGECHK_EN
    send(8'd251, 8'd1, 1'b0, 8'd0, 1'b1, 1'b0);
`else
    send(8'd251, 8'd1, 1'b0, 8'd1, 1'b0, 1'b1);
`endif
    drain();

    // Five back-to-back adds with a three-cycle output stall.
    fork
      begin
        send(8'd1, 8'd2, 1'b0, 8'd3, 1'b0, 1'b0);
        send(8'd250, 8'd250, 1'b0, 8'd249, 1'b0, 1'b1);
        send(8'd100, 8'd151, 1'b0, 8'd0, 1'b0, 1'b1);
        send(8'd0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0);
        send(8'd17, 8'd30, 1'b0, 8'd47, 1'b0, 1'b0);
      end
      begin
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("stall_in_ready", 32'(in_ready), 32'd0);
          chk("stall_out_valid", 32'(out_valid), 32'd1);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Drive the counter into saturation.
    for (int i = 0; i < 40; i++) send(8'd200, 8'd100, 1'b0, 8'd49, 1'b0, 1'b1);
    drain();
    chk("cnt_saturated", 32'(red_cnt), CNT_SAT);
    send(8'd10, 8'd20, 1'b1, 8'd241, 1'b0, 1'b1);
    drain();
    chk("cnt_stays_saturated", 32'(red_cnt), CNT_SAT);

    // Reset with two operand pairs in flight.
    send(8'd200, 8'd100, 1'b0, 8'd49, 1'b0, 1'b1);
    send(8'd250, 8'd250, 1'b0, 8'd249, 1'b0, 1'b1);
    chk("inflight_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_red_cnt", 32'(red_cnt), 32'd0);
    chk("midrst_result", 32'(result), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_after_midrst", 32'(in_ready), 32'd1);
    repeat (6) @(negedge clk);
    chk("no_stale_valid", 32'(out_valid), 32'd0);
    chk("cnt_after_midrst", 32'(red_cnt), 32'd0);
    @(posedge clk);
    #1;

    // Clear wins over a simultaneous correcting delivery.
    send(8'd200, 8'd100, 1'b0, 8'd49, 1'b0, 1'b1);
    send(8'd10, 8'd20, 1'b1, 8'd241, 1'b0, 1'b1);
    drain();
    chk("cnt_before_clr", 32'(red_cnt), 32'd2);
    send(8'd200, 8'd100, 1'b0, 8'd49, 1'b0, 1'b1);
    cnt_clr = 1'b1;
    repeat (3) @(posedge clk);
    #1 cnt_clr = 1'b0;
    @(negedge clk);
    chk("cnt_clr_priority", 32'(red_cnt), 32'd0);
    chk("clr_queue_empty", 32'(exp_q.size()), 32'd0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
